// File: rtl/rom_reader_if.sv
// Burst-read bus between a controller, a combinational ROM and the rom_reader block.
interface rom_reader_if #(
  parameter int N = 8
);
  logic         start;
  logic         abort;
  logic         loop;
  logic [N-1:0] base_addr;
  logic [N-1:0] count;
  logic [N-1:0] rom_addr;
  logic [N-1:0] rom_data;
  logic [N-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;
  logic         done;

  modport master (
    output start, abort, loop, base_addr, count, rom_data, dout_ready,
    input  rom_addr, dout, dout_valid, busy, done
  );

  modport slave (
    input  start, abort, loop, base_addr, count, rom_data, dout_ready,
    output rom_addr, dout, dout_valid, busy, done
  );
endinterface

// File: rtl/rom_reader.sv
// Streams a burst of ROM words to a valid/ready consumer; rom_addr from the start edge, dout one edge later.
// One word per 2 cycles at best; dout/dout_valid/rom_addr hold while dout_ready is low.
module rom_reader #(
  parameter int N     = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rom_reader_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  localparam logic [N-1:0] DEPTH_N = N'(DEPTH);
  localparam logic [N-1:0] LAST    = N'(DEPTH - 1);
  localparam logic [N-1:0] ONE     = N'(1);

  state_t       state;
  logic [N-1:0] ptr;
  logic [N-1:0] base_q;
  logic [N-1:0] count_q;
  logic [N-1:0] remaining;
  logic         loop_q;
  logic [N-1:0] dout_q;
  logic         dout_valid_q;
  logic         busy_q;
  logic         done_q;

  assign bus.rom_addr   = ptr;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      base_q       <= '0;
      count_q      <= '0;
      remaining    <= '0;
      loop_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (state != IDLE && bus.abort) begin
      // Abort beats any handshake in the same cycle and never produces done.
      state        <= IDLE;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            ptr       <= bus.base_addr % DEPTH_N;
            base_q    <= bus.base_addr % DEPTH_N;
            count_q   <= bus.count;
            remaining <= bus.count;
            loop_q    <= bus.loop;
            busy_q    <= 1'b1;
            if (bus.count == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= FETCH;
            end
          end
        end
        FETCH: begin
          dout_q       <= bus.rom_data;
          dout_valid_q <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (dout_valid_q && bus.dout_ready) begin
            dout_valid_q <= 1'b0;
            if (remaining > ONE) begin
              ptr       <= (ptr == LAST) ? '0 : ptr + ONE;
              remaining <= remaining - ONE;
              state     <= FETCH;
            end else if (loop_q) begin
              ptr       <= base_q;
              remaining <= count_q;
              state     <= FETCH;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          dout_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader against a rom[i] = 8'hA0 + i model, DEPTH = 8.
module tb_rom_reader;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   done_cnt  = 0;
  int   valid_cnt = 0;

  rom_reader_if #(.N(8)) bus();

  rom_reader #(.N(8), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rom_data = 8'hA0 + bus.rom_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.dout_valid) valid_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [7:0] b, input logic [7:0] c, input logic l);
    bus.base_addr = b;
    bus.count     = c;
    bus.loop      = l;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  // Records the word at the next handshake, then steps past that handshake edge.
  task automatic next_word(output logic [7:0] w, output logic [7:0] a);
    bit got;
    got = 1'b0;
    w = '0;
    a = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.dout_valid && bus.dout_ready) begin
        w = bus.dout;
        a = bus.rom_addr;
        got = 1'b1;
      end
      tick();
    end
    chk("word_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_valid();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.dout_valid) got = 1'b1;
      else tick();
    end
    chk("valid_timeout", {31'd0, got}, 32'd1);
  endtask

  logic [7:0] w, a, held;
  int d0, v0;
  logic [7:0] exp_d[4];
  logic [7:0] exp_a[4];

  initial begin
    rst_n          = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.loop       = 1'b0;
    bus.base_addr  = '0;
    bus.count      = '0;
    bus.dout_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", bus.busy, 0);

    // Basic burst: base 2, count 3.
    bus.dout_ready = 1'b1;
    d0 = done_cnt;
    kick(8'd2, 8'd3, 1'b0);
    chk("b1_addr_k", bus.rom_addr, 2);
    chk("b1_busy_k", bus.busy, 1);
    chk("b1_valid_k", bus.dout_valid, 0);
    tick();
    chk("b1_dout_k1", bus.dout, 8'hA2);
    chk("b1_valid_k1", bus.dout_valid, 1);
    for (int i = 0; i < 3; i++) begin
      next_word(w, a);
      chk("b1_word", w, 8'hA2 + i);
    end
    chk("b1_done", bus.done, 1);
    chk("b1_busy_done", bus.busy, 1);
    tick();
    chk("b1_done_fall", bus.done, 0);
    chk("b1_busy_fall", bus.busy, 0);
    chk("b1_dout_kept", bus.dout, 8'hA4);
    chk("b1_done_once", done_cnt, d0 + 1);

    // Wrap modulo DEPTH.
    exp_d = '{8'hA6, 8'hA7, 8'hA0, 8'hA1};
    exp_a = '{8'd6, 8'd7, 8'd0, 8'd1};
    kick(8'd6, 8'd4, 1'b0);
    chk("wrap_addr_k", bus.rom_addr, 6);
    for (int i = 0; i < 4; i++) begin
      next_word(w, a);
      chk("wrap_word", w, exp_d[i]);
      chk("wrap_addr", a, exp_a[i]);
    end
    chk("wrap_done", bus.done, 1);
    tick();

    // Base beyond DEPTH folds back: 10 mod 8 = 2.
    kick(8'd10, 8'd1, 1'b0);
    chk("fold_addr", bus.rom_addr, 2);
    next_word(w, a);
    chk("fold_word", w, 8'hA2);
    chk("fold_done", bus.done, 1);
    tick();

    // Backpressure on the second word.
    bus.dout_ready = 1'b0;
    kick(8'd2, 8'd3, 1'b0);
    tick();
    chk("bp_w1_valid", bus.dout_valid, 1);
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_dout", bus.dout, 8'hA3);
      chk("bp_hold_valid", bus.dout_valid, 1);
      chk("bp_hold_addr", bus.rom_addr, 3);
      tick();
    end
    bus.dout_ready = 1'b1;
    next_word(w, a);
    chk("bp_w2", w, 8'hA3);
    next_word(w, a);
    chk("bp_w3", w, 8'hA4);
    chk("bp_done", bus.done, 1);
    tick();

    // Looping burst, then abort racing a handshake.
    d0 = done_cnt;
    kick(8'd0, 8'd2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      next_word(w, a);
      chk("loop_word", w, (i % 2 == 0) ? 8'hA0 : 8'hA1);
    end
    chk("loop_no_done", done_cnt, d0);
    wait_valid();
    held = bus.dout;
    chk("loop_held", held, 8'hA0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.dout_valid, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_dout_kept", bus.dout, held);
    tick();
    chk("abort_idle", bus.busy, 0);
    chk("abort_no_done", done_cnt, d0);

    // Zero-length burst.
    v0 = valid_cnt;
    d0 = done_cnt;
    kick(8'd4, 8'd0, 1'b0);
    chk("zero_done", bus.done, 1);
    chk("zero_busy", bus.busy, 1);
    chk("zero_valid", bus.dout_valid, 0);
    tick();
    chk("zero_done_fall", bus.done, 0);
    chk("zero_busy_fall", bus.busy, 0);
    chk("zero_no_valid", valid_cnt, v0);
    chk("zero_done_once", done_cnt, d0 + 1);

    // Abort with start in IDLE: nothing starts.
    bus.abort = 1'b1;
    kick(8'd5, 8'd3, 1'b0);
    bus.abort = 1'b0;
    chk("abst_busy", bus.busy, 0);
    chk("abst_addr", bus.rom_addr, 4);

    // Start re-pulsed mid-burst with new parameters is ignored.
    bus.dout_ready = 1'b0;
    kick(8'd1, 8'd2, 1'b0);
    bus.base_addr = 8'd5;
    bus.count     = 8'd7;
    bus.start     = 1'b1;
    tick();
    tick();
    tick();
    bus.start      = 1'b0;
    bus.dout_ready = 1'b1;
    next_word(w, a);
    chk("restart_w1", w, 8'hA1);
    next_word(w, a);
    chk("restart_w2", w, 8'hA2);
    chk("restart_done", bus.done, 1);
    tick();
    chk("restart_idle", bus.busy, 0);

    // Asynchronous reset mid-burst.
    kick(8'd3, 8'd4, 1'b0);
    next_word(w, a);
    chk("ar_w1", w, 8'hA3);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_addr", bus.rom_addr, 0);
    chk("ar_dout", bus.dout, 0);
    chk("ar_valid", bus.dout_valid, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_done", bus.done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("ar_wait_idle", bus.busy, 0);
    chk("ar_no_done", done_cnt, d0);
    kick(8'd5, 8'd2, 1'b0);
    next_word(w, a);
    chk("ar_new_w1", w, 8'hA5);
    next_word(w, a);
    chk("ar_new_w2", w, 8'hA6);
    chk("ar_new_done", bus.done, 1);
    tick();
    chk("ar_new_done_once", done_cnt, d0 + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_reader.md
ROM_READER -- requirements
Module: rom_reader

Interface
REQ-001 Parameter N, default 8: data and address width in bits.
REQ-002 Parameter DEPTH, default 8: number of ROM words; legal addresses are 0..DEPTH-1.
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a burst; sampled only in IDLE.
REQ-006 abort  input  1  terminate the burst in progress.
REQ-007 loop  input  1  restart the burst from base after the last word; sampled at start.
REQ-008 base_addr  input  N  first ROM address of the burst; sampled at start.
REQ-009 count  input  N  number of words in the burst; sampled at start.
REQ-010 rom_addr  output  N  registered address driven to the downstream combinational ROM.
REQ-011 rom_data  input  N  ROM read data for rom_addr, valid in the same cycle.
REQ-012 dout  output  N  registered data word.
REQ-013 dout_valid  output  1  dout holds a word not yet accepted.
REQ-014 dout_ready  input  1  consumer accepts dout when dout_valid is also high.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at normal burst completion.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, FETCH, HOLD, DONE.
REQ-018 IDLE with start=1: latch base_addr into ptr and rom_addr, latch count into remaining, latch loop; if count=0 go to DONE, else go to FETCH.
REQ-019 FETCH: capture rom_data into dout, set dout_valid=1, go to HOLD (one cycle).
REQ-020 HOLD, no handshake: dout and dout_valid held stable, rom_addr unchanged.
REQ-021 HOLD, handshake (dout_valid & dout_ready): clear dout_valid; if remaining>1, ptr=ptr+1 with wrap DEPTH-1 -> 0, remaining-1, go to FETCH.
REQ-022 HOLD, handshake on the last word (remaining=1): if loop latched, reload ptr=base and remaining=count, go to FETCH; else go to DONE.
REQ-023 DONE: done=1 for exactly one cycle, go to IDLE.
REQ-024 rom_addr SHALL always equal ptr; no other output SHALL depend combinationally on the inputs.
REQ-025 Latency: with start at edge k, rom_addr=base from k; dout_valid rises at edge k+1; peak throughput is one word per 2 cycles.
REQ-026 Address arithmetic SHALL be modulo DEPTH, not modulo 2^N; base_addr >= DEPTH is treated as base_addr mod DEPTH.
REQ-027 start while busy SHALL be ignored; base/count/loop SHALL NOT be re-sampled mid-burst.
REQ-028 abort in any non-IDLE state: next state IDLE, dout_valid=0, done stays 0, and abort takes priority over a simultaneous handshake.
REQ-029 abort in IDLE SHALL be ignored; abort together with start in IDLE: abort wins, state stays IDLE.
REQ-030 dout SHALL retain its last captured value in IDLE and DONE.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, ptr=0, rom_addr=0, remaining=0, dout=0, dout_valid=0, done=0, busy=0, loop latch=0.
REQ-032 Reset asserted mid-burst SHALL discard the burst, and no done pulse SHALL occur; after release the block waits in IDLE for a new start.

Verification
(ROM model: rom[i]=8'hA0+i, DEPTH=8.)
REQ-033 base=2, count=3, ready=1 -> dout A2,A3,A4 on successive handshakes, done pulses once, busy falls the cycle after.
REQ-034 base=6, count=4 -> rom_addr 6,7,0,1; dout A6,A7,A0,A1 (wrap modulo DEPTH).
REQ-035 ready held 0 for 5 cycles on word 2 -> dout=A3 and dout_valid=1 stable throughout; no loss or duplication after ready=1.
REQ-036 loop=1, base=0, count=2 -> A0,A1,A0,A1,... with no done pulse; abort -> IDLE next cycle, dout_valid=0, done=0.
REQ-037 count=0 -> done pulse 1 cycle after start, dout_valid never asserted; start pulsed mid-burst -> ignored.
REQ-038 rst_n low mid-burst (asynchronous, between edges) -> all outputs reach reset values immediately; a new start after release runs correctly.
